// File: rtl/mpy16_pkg.sv
// rtl/mpy16_pkg.sv - shared types and phase constants for the sequential 16x16 multiplier.
package mpy16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] PH_LL = 2'd0;
  localparam logic [1:0] PH_LH = 2'd1;
  localparam logic [1:0] PH_HL = 2'd2;
  localparam logic [1:0] PH_HH = 2'd3;

  // Left shift applied to each byte-pair partial before accumulation.
  function automatic logic [4:0] phase_shift(input logic [1:0] ph);
    case (ph)
      PH_LL:   return 5'd0;
      PH_LH:   return 5'd8;
      PH_HL:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mpy16_seq_if.sv
// rtl/mpy16_seq_if.sv - operand/product handshake bundle for mpy16_seq.
interface mpy16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        a_signed;
  logic        b_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  modport master (
    output in_valid, a, b, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, a_signed, b_signed, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mpy16_phase_sel.sv
// rtl/mpy16_phase_sel.sv - picks the byte pair, sign flags and shift for each multiply phase.
module mpy16_phase_sel
  import mpy16_pkg::*;
(
  input  logic [1:0]  phase,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        a_signed,
  input  logic        b_signed,
  output logic [7:0]  mpd,
  output logic [7:0]  mpr,
  output logic        signed_mpd,
  output logic        signed_mpr,
  output logic [4:0]  shift
);

  always_comb begin
    mpd        = a[7:0];
    mpr        = b[7:0];
    signed_mpd = 1'b0;
    signed_mpr = 1'b0;
    case (phase)
      PH_LL: ;
      PH_LH: begin
        mpr        = b[15:8];
        signed_mpr = b_signed;
      end
      PH_HL: begin
        mpd        = a[15:8];
        signed_mpd = a_signed;
      end
      default: begin
        mpd        = a[15:8];
        mpr        = b[15:8];
        signed_mpd = a_signed;
        signed_mpr = b_signed;
      end
    endcase
    shift = phase_shift(phase);
  end

endmodule

// File: rtl/mpy8x8.sv
// rtl/mpy8x8.sv - combinational 8x8 multiplier leaving its result as a carry-save pair.
module mpy8x8 (
  input  logic [7:0]  mpd,
  input  logic [7:0]  mpr,
  input  logic        signed_mpd,
  input  logic        signed_mpr,
  output logic [15:0] csa_a,
  output logic [15:0] csa_b
);

  logic [15:0] mpd_ext;
  logic [15:0] row;
  logic [15:0] s;
  logic [15:0] c;
  logic [15:0] ns;
  logic [15:0] nc;

  assign mpd_ext = {{8{signed_mpd & mpd[7]}}, mpd};

  always_comb begin
    s = '0;
    c = '0;
    row = '0;
    ns = '0;
    nc = '0;
    for (int i = 0; i < 8; i++) begin
      row = mpr[i] ? (mpd_ext << i) : 16'd0;
      // A signed multiplier's top bit carries negative weight: add ~row here, +1 below.
      if (i == 7 && signed_mpr) row = ~row;
      ns = s ^ c ^ row;
      nc = ((s & c) | (s & row) | (c & row)) << 1;
      s  = ns;
      c  = nc;
    end
    csa_a = s;
    csa_b = c | {15'd0, signed_mpr};
  end

endmodule

// File: rtl/mpy16_seq.sv
// rtl/mpy16_seq.sv - 16x16 multiplier stepping four byte-pair products through one mpy8x8.
// Build option MPY16_ZERO_SKIP_EN: a zero operand bypasses MUL and completes in one cycle.
module mpy16_seq
  import mpy16_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input logic        clk,
  input logic        rst_n,
  mpy16_seq_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        phase;
  logic [15:0]       a_q;
  logic [15:0]       b_q;
  logic              a_signed_q;
  logic              b_signed_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  product_q;
  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              zero_op;

  logic [7:0]        mpd;
  logic [7:0]        mpr;
  logic              signed_mpd;
  logic              signed_mpr;
  logic [4:0]        shift;
  logic [15:0]       csa_a;
  logic [15:0]       csa_b;
  logic [15:0]       p16;
  logic [ACC_W-1:0]  ext;
  logic [ACC_W-1:0]  acc_sum;

  mpy16_phase_sel u_phase_sel (
    .phase      (phase),
    .a          (a_q),
    .b          (b_q),
    .a_signed   (a_signed_q),
    .b_signed   (b_signed_q),
    .mpd        (mpd),
    .mpr        (mpr),
    .signed_mpd (signed_mpd),
    .signed_mpr (signed_mpr),
    .shift      (shift)
  );

  mpy8x8 u_mpy8x8 (
    .mpd        (mpd),
    .mpr        (mpr),
    .signed_mpd (signed_mpd),
    .signed_mpr (signed_mpr),
    .csa_a      (csa_a),
    .csa_b      (csa_b)
  );

  assign p16     = csa_a + csa_b;
  assign ext     = (signed_mpd | signed_mpr) ? {{(ACC_W-16){p16[15]}}, p16}
                                             : {{(ACC_W-16){1'b0}}, p16};
  assign acc_sum = acc + (ext << shift);

  assign accept  = bus.in_valid & in_ready;
`ifdef MPY16_ZERO_SKIP_EN
  assign zero_op = (bus.a == 16'd0) | (bus.b == 16'd0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nx = zero_op ? DONE : MUL;
      end
      MUL: begin
        if (phase == PH_HH) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= PH_LL;
      a_q        <= '0;
      b_q        <= '0;
      a_signed_q <= 1'b0;
      b_signed_q <= 1'b0;
      acc        <= '0;
      product_q  <= '0;
    end else begin
      if (accept) begin
        a_q        <= bus.a;
        b_q        <= bus.b;
        a_signed_q <= bus.a_signed;
        b_signed_q <= bus.b_signed;
        acc        <= '0;
        phase      <= PH_LL;
        if (zero_op) product_q <= '0;
      end else if (state == MUL) begin
        acc   <= acc_sum;
        phase <= phase + 2'd1;
        if (phase == PH_HH) product_q <= acc_sum;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.product   = product_q[31:0];

endmodule

// File: tb/tb_mpy16_seq.sv
// tb/tb_mpy16_seq.sv - randomized and directed checks of mpy16_seq against an arithmetic model.
module tb_mpy16_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

`ifdef MPY16_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  always #5 clk = ~clk;

  mpy16_seq_if bus ();

  mpy16_seq #(.ACC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        as;
    logic        bs;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic as, input logic bs);
    longint va;
    longint vb;
    longint p;
    va = as ? longint'($signed(a)) : longint'(a);
    vb = bs ? longint'($signed(b)) : longint'(b);
    p  = va * vb;
    return p[31:0];
  endfunction

  function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
    return (ZERO_SKIP && (a == 16'd0 || b == 16'd0)) ? 1 : 5;
  endfunction

  // Called just after a rising edge with the DUT idle; returns the product and
  // the number of edges from the accepting edge (inclusive) to out_valid.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic as,
                       input logic bs, output logic [31:0] p, output int lat);
    bus.a        = a;
    bus.b        = b;
    bus.a_signed = as;
    bus.b_signed = bs;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus.product;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.a_signed  = 1'b0;
    bus.b_signed  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.product !== 32'd0) begin
      failures++; $display("FAIL reset_product got=%h exp=00000000", bus.product);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t        v[7];
    logic [31:0] p;
    int          lat;
    v[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 32'h06260060};
    v[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 32'h00000001};
    v[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001};
    v[3] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000};
    v[4] = '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 32'hC0008000};
    v[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFF0001};
    v[6] = '{16'h0003, 16'h0005, 1'b0, 1'b0, 32'h0000000F};
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].a, v[i].b, v[i].as, v[i].bs, p, lat);
      checks++;
      if (p !== v[i].exp) begin
        failures++; $display("FAIL directed_product[%0d] got=%h exp=%h", i, p, v[i].exp);
      end
      checks++;
      if (lat !== 5) begin
        failures++; $display("FAIL directed_latency[%0d] got=%0d exp=5", i, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic        as;
    logic        bs;
    logic [31:0] p;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      as = 1'($urandom);
      bs = 1'($urandom);
      case ($urandom_range(0, 7))
        0: a = 16'd0;
        1: b = 16'd0;
        2: a = 16'h8000;
        default: ;
      endcase
      do_op(a, b, as, bs, p, lat);
      checks++;
      if (p !== ref_mul(a, b, as, bs)) begin
        failures++;
        $display("FAIL random_product a=%h b=%h s=%b%b got=%h exp=%h",
                 a, b, as, bs, p, ref_mul(a, b, as, bs));
      end
      checks++;
      if (lat !== exp_lat(a, b)) begin
        failures++; $display("FAIL random_latency got=%0d exp=%0d", lat, exp_lat(a, b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    logic [31:0] p;
    int          lat;
    a   = 16'($urandom) | 16'h0101;
    b   = 16'($urandom) | 16'h0101;
    exp = ref_mul(a, b, 1'b1, 1'b0);
    bus.a = a; bus.b = b; bus.a_signed = 1'b1; bus.b_signed = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 5) begin
      failures++; $display("FAIL bp_latency got=%0d exp=5", lat);
    end
    for (int i = 0; i < 10; i++) begin
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.in_valid = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.product} !== {1'b1, 1'b0, exp}) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=v%b r%b %h exp=v1 r0 %h",
                 i, bus.out_valid, bus.in_ready, bus.product, exp);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release got=v%b r%b exp=v0 r1", bus.out_valid, bus.in_ready);
    end
    a = 16'h00C3; b = 16'hFF10;
    do_op(a, b, 1'b0, 1'b1, p, lat);
    checks++;
    if (p !== ref_mul(a, b, 1'b0, 1'b1)) begin
      failures++; $display("FAIL bp_next_product got=%h exp=%h", p, ref_mul(a, b, 1'b0, 1'b1));
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] p;
    int          lat;
    bus.a = 16'h1234; bus.b = 16'h5678; bus.a_signed = 1'b0; bus.b_signed = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.product} !== {1'b0, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL midreset_state got=v%b r%b %h exp=v0 r1 00000000",
               bus.out_valid, bus.in_ready, bus.product);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0003, 16'h0005, 1'b0, 1'b0, p, lat);
    checks++;
    if (p !== 32'h0000000F) begin
      failures++; $display("FAIL midreset_next got=%h exp=0000000f", p);
    end
    checks++;
    if (lat !== 5) begin
      failures++; $display("FAIL midreset_latency got=%0d exp=5", lat);
    end
  endtask

  task automatic test_zero_operand();
    logic [31:0] p;
    int          lat;
    do_op(16'h0000, 16'h1234, 1'b0, 1'b0, p, lat);
    checks++;
    if (p !== 32'd0) begin
      failures++; $display("FAIL zero_product got=%h exp=00000000", p);
    end
    checks++;
    if (lat !== exp_lat(16'h0000, 16'h1234)) begin
      failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, exp_lat(16'h0000, 16'h1234));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_mul();
    test_zero_operand();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpy16_seq.md
Name: mpy16_seq

Overview:
- Multi-cycle 16x16 multiplier controller built around one shared 8x8 Booth/Wallace carry-save multiplier (MPY8x8).
- Captures a 16-bit operand pair on a valid/ready handshake and steps the four byte-pair partial products through the single MPY8x8 instance, one per cycle.
- Resolves each carry-save pair to a 16-bit partial, then shifts and accumulates into a 32-bit product.
- Serves the audio/DSP datapath wherever a full-width multiply is needed but only one 8x8 multiplier is budgeted.

Parameters:
- ACC_W, 32, accumulator/product width; fixed at 2x operand width, other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  16  multiplicand.
- b  in  16  multiplier.
- a_signed  in  1  a is two's complement.
- b_signed  in  1  b is two's complement.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- product  out  32  a*b, signed if either operand is signed.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, product=0, acc=0, phase=0. Takes effect mid-operation; any in-flight multiply is discarded.
- States: IDLE, MUL, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register a, b, a_signed, b_signed; clear acc; phase=0; go to MUL.
- MUL: in_ready=0. phase 0..3 selects MPY8x8 inputs, {multiplicand, multiplier, signed_MPD, signed_MPR}, with shift:
  - phase 0: a[7:0], b[7:0], 0, 0; shift 0.
  - phase 1: a[7:0], b[15:8], 0, b_signed; shift 8.
  - phase 2: a[15:8], b[7:0], a_signed, 0; shift 8.
  - phase 3: a[15:8], b[15:8], a_signed, b_signed; shift 16.
- Per phase:
  - p16 = (csa_a + csa_b) mod 2^16.
  - Sign-extend p16 to 32 bits iff (signed_MPD | signed_MPR) for that phase; otherwise zero-extend.
  - acc <= acc + (ext << shift), mod 2^32.
- After phase 3, go to DONE with product <= final acc.
- DONE: out_valid=1 and product held stable until out_ready. On out_valid&out_ready, go to IDLE.
- in_ready stays 0 in DONE, so no overlap.
- Latency: accept edge to out_valid = 5 cycles; throughput 1 result per 6 cycles with out_ready tied high.
- out_ready asserted in IDLE/MUL is ignored.
- in_valid asserted outside IDLE is ignored; the operands are not sampled.
- A new accept may occur in the cycle after the output handshake, not the same cycle.
- Multiplier path is purely combinational within one cycle; no state is held inside MPY8x8.

Optional Feature:
- Macro MPY16_ZERO_SKIP_EN.
- Defined: in IDLE, an accept with a==0 or b==0 goes directly to DONE with product=0. Latency is 1 cycle; MUL is not entered.
- Undefined: every operand pair takes the full 4-phase MUL sequence.

Decomposition:
- Package mpy16_pkg holds:
  - state enum {IDLE, MUL, DONE};
  - phase constants PH_LL=0, PH_LH=1, PH_HL=2, PH_HH=3;
  - shift table {0, 8, 8, 16}.
- One sub-module: mpy16_phase_sel, combinational.
  - Inputs: phase, registered operands, sign flags.
  - Outputs: MPY8x8 operand/sign inputs and the shift amount.
- Accumulator, FSM and the single MPY8x8 instance live in mpy16_seq.

Test Plan:
- Unsigned: a=0x1234, b=0x5678, signs 0/0 -> product=0x06260060; out_valid exactly 5 cycles after accept.
- Signed -1*-1: a=0xFFFF, b=0xFFFF, signs 1/1 -> 0x00000001. Same operands with signs 0/0 -> 0xFFFE0001.
- Signed extremes, signs 1/1:
  - 0x8000*0x8000 -> 0x40000000;
  - 0x8000*0x7FFF -> 0xC0008000.
- Mixed: a=0xFFFF signed, b=0xFFFF unsigned -> 0xFFFF0001.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Required: product stable, in_ready=0, in_valid pulses ignored. Release -> handshake, then IDLE and in_ready=1 next cycle.
- Reset mid-MUL: drop rst_n at phase 2 -> out_valid=0, product=0, in_ready=1 immediately. A following 3*5 (0x0003, 0x0005, unsigned) -> 0x0000000F.
- With MPY16_ZERO_SKIP_EN: a=0, b=0x1234 -> product=0 with out_valid 1 cycle after accept.
